pcie_rx_mwr_axi_master: RTL
===========================

Name: pcie_rx_mwr_axi_master

Overview:
- Receive-side counterpart of the PCIe TX path: takes one inbound TLP per handshake (header fields + up to 4 DW payload).
- Memory-Write TLPs become single-beat AXI write transactions (AW, W, B) toward the memory subsystem.
- All other TLP kinds and malformed TLPs are dropped and counted.
- Sits between the PCIe RX link-side decoder and the AXI interconnect, mirroring the AXI slave role that the PCIe TX path exposes.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on awid; also the required bid.
- CNT_WIDTH, 16, width of the saturating status counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- tlp_valid_i  in  1  TLP present
- tlp_ready_o  out  1  TLP accepted when valid&ready
- tlp_fmt_i  in  3  TLP fmt
- tlp_type_i  in  5  TLP type
- tlp_tc_i  in  3  traffic class (ignored, no effect)
- tlp_length_i  in  9  payload length in DW
- tlp_reqid_i  in  16  requester ID (latched for status)
- tlp_addr_i  in  32  byte address
- tlp_data_i  in  128  payload, DW0 in bits [31:0]
- awvalid_o  out  1  AXI AW valid
- awready_i  in  1  AXI AW ready
- awid_o  out  ID_WIDTH  AXI AW ID
- awaddr_o  out  32  AXI AW address
- awlen_o  out  8  AXI AW burst length
- awsize_o  out  3  AXI AW beat size
- awburst_o  out  2  AXI AW burst type
- wvalid_o  out  1  AXI W valid
- wready_i  in  1  AXI W ready
- wdata_o  out  128  AXI W data
- wstrb_o  out  16  AXI W byte strobes
- wlast_o  out  1  AXI W last
- bvalid_i  in  1  AXI B valid
- bready_o  out  1  AXI B ready
- bid_i  in  ID_WIDTH  AXI B ID
- bresp_i  in  2  AXI B response
- wr_done_cnt_o  out  CNT_WIDTH  completed writes with good response
- drop_cnt_o  out  CNT_WIDTH  unsupported or malformed TLPs
- err_cnt_o  out  CNT_WIDTH  bad B responses
- last_reqid_o  out  16  requester ID of the last accepted MWr

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All valid outputs, bready_o and tlp_ready_o are 0.
  - Counters, last_reqid_o and all AW/W payload registers are 0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - tlp_ready_o=1. Every accepted TLP is classified in the acceptance cycle.
  - MWr means fmt=3'b010 (3DW with data) and type=5'b00000.
  - Anything else: drop_cnt++, stay IDLE.
  - Malformed MWr: length==0, or addr[3:2]+length>4 (crosses a 16B line). drop_cnt++, stay IDLE.
  - Valid MWr → ISSUE next cycle:
    - register awaddr=addr & ~32'hF, awlen=0, awsize=3'b100, awburst=2'b01, awid=AXI_ID, wlast=1;
    - wdata = tlp_data_i shifted left by addr[3:2]*32;
    - wstrb = ((1<<(4*length))-1) << (4*addr[3:2]);
    - last_reqid=reqid.
- ISSUE:
  - tlp_ready_o=0. awvalid_o and wvalid_o both assert in the first ISSUE cycle.
  - Each channel deasserts independently on its own handshake; payload is held stable while valid.
  - AW and W may complete in either order or the same cycle; W may complete before AW.
  - When both are done → RESP.
- RESP:
  - bready_o=1.
  - On bvalid: if bid==AXI_ID and bresp==2'b00, wr_done_cnt++; else err_cnt++.
  - Then → IDLE. tlp_ready_o returns to 1 in the cycle after B completes.
- Throughput: one outstanding write at most.
  - Minimum MWr-to-MWr spacing is 3 cycles: accept, ISSUE (AW and W ready same cycle), RESP (bvalid that cycle).
- Counters saturate at all-ones; no wrap.
- Combinational paths: the only one is tlp_ready_o from state; no input→output combinational paths.
- Reset mid-ISSUE/RESP: immediate return to IDLE, valids drop. The in-flight write is abandoned and not counted.
- tlp_tc_i: ignored (no effect on any output).

Test Plan:
- MWr addr=0x0, len=4, data={4{32'h01234567}}, AW/W ready immediately, bresp=0:
  - awaddr=0x0, wstrb=16'hFFFF, wdata unchanged;
  - wr_done_cnt=1;
  - next TLP accepted 3 cycles after first.
- MWr addr=0x24, len=1, data[31:0]=32'hDEADBEEF:
  - awaddr=0x20, wstrb=16'h00F0, wdata[63:32]=32'hDEADBEEF.
- MWr addr=0x28, len=3 (crosses line):
  - no AW/W issued, drop_cnt=1.
- Memory-Read TLP (fmt=3'b000):
  - no AW/W issued, drop_cnt=1.
- MWr with wready held low 5 cycles, awready immediate:
  - awvalid drops after 1 cycle;
  - wvalid stays high with stable wdata/wstrb until wready;
  - single B then wr_done_cnt=1.
- MWr with bresp=2'b10:
  - err_cnt=1, wr_done_cnt unchanged.
- Same MWr with bid≠AXI_ID:
  - err_cnt=2.
- Assert rst during ISSUE:
  - all valids 0 and counters 0 in the same cycle;
  - next MWr completes normally.

Source files
------------

// File: rtl/pcie_rx_mwr_axi_master.sv
// pcie_rx_mwr_axi_master: turns inbound PCIe Memory-Write TLPs into single-beat AXI writes
//   clk, rst            clock, asynchronous active-high reset
//   tlp_*               inbound TLP header fields and 4-DW payload, valid/ready handshake
//   aw*, w*, b*         AXI write address / data / response channels (one outstanding write)
//   *_cnt_o             saturating counters: good writes, dropped TLPs, bad responses
//   last_reqid_o        requester ID of the most recently accepted MWr
module pcie_rx_mwr_axi_master #(
    parameter int ID_WIDTH  = 4,
    parameter int AXI_ID    = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tlp_valid_i,
    output logic                 tlp_ready_o,
    input  logic [2:0]           tlp_fmt_i,
    input  logic [4:0]           tlp_type_i,
    input  logic [2:0]           tlp_tc_i,
    input  logic [8:0]           tlp_length_i,
    input  logic [15:0]          tlp_reqid_i,
    input  logic [31:0]          tlp_addr_i,
    input  logic [127:0]         tlp_data_i,
    output logic                 awvalid_o,
    input  logic                 awready_i,
    output logic [ID_WIDTH-1:0]  awid_o,
    output logic [31:0]          awaddr_o,
    output logic [7:0]           awlen_o,
    output logic [2:0]           awsize_o,
    output logic [1:0]           awburst_o,
    output logic                 wvalid_o,
    input  logic                 wready_i,
    output logic [127:0]         wdata_o,
    output logic [15:0]          wstrb_o,
    output logic                 wlast_o,
    input  logic                 bvalid_i,
    output logic                 bready_o,
    input  logic [ID_WIDTH-1:0]  bid_i,
    input  logic [1:0]           bresp_i,
    output logic [CNT_WIDTH-1:0] wr_done_cnt_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic [15:0]          last_reqid_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t r_state, w_next;
    logic                 r_tlp_ready, r_awvalid, r_wvalid, r_wlast;
    logic [ID_WIDTH-1:0]  r_awid;
    logic [31:0]          r_awaddr;
    logic [7:0]           r_awlen;
    logic [2:0]           r_awsize;
    logic [1:0]           r_awburst;
    logic [127:0]         r_wdata;
    logic [15:0]          r_wstrb, r_reqid;
    logic [CNT_WIDTH-1:0] r_done_cnt, r_drop_cnt, r_err_cnt;
    logic                 w_accept, w_is_mwr, w_bad, w_go, w_drop, w_aw_done, w_w_done, w_b_done, w_b_ok;
    logic [9:0]           w_end;
    logic [15:0]          w_len_mask;
    logic                 w_unused;
    // Traffic class and the sub-DW address bits carry no meaning for this path.
    assign w_unused   = &{1'b0, tlp_tc_i, tlp_addr_i[1:0]};
    assign w_accept   = tlp_valid_i & r_tlp_ready;
    assign w_is_mwr   = tlp_fmt_i == 3'b010 && tlp_type_i == 5'b00000;
    // Payload must start and end inside one 16-byte AXI beat.
    assign w_end      = {8'd0, tlp_addr_i[3:2]} + {1'b0, tlp_length_i};
    assign w_bad      = tlp_length_i == 9'd0 || w_end > 10'd4;
    assign w_go       = w_accept & w_is_mwr & ~w_bad;
    assign w_drop     = w_accept & ~(w_is_mwr & ~w_bad);
    // Length is 1..4 whenever the mask is used, so a shift of 16 yields all ones.
    assign w_len_mask = ~(16'hFFFF << {tlp_length_i[2:0], 2'b00});
    assign w_aw_done  = ~r_awvalid | awready_i;
    assign w_w_done   = ~r_wvalid | wready_i;
    assign w_b_done   = r_state == RESP && bvalid_i;
    assign w_b_ok     = bid_i == ID_WIDTH'(AXI_ID) && bresp_i == 2'b00;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE) w_next = w_go ? ISSUE : IDLE;
        else if (r_state == ISSUE) w_next = (w_aw_done && w_w_done) ? RESP : ISSUE;
        else if (r_state == RESP) w_next = bvalid_i ? IDLE : RESP;
    end
    always_comb begin
        bready_o    = r_state == RESP;
        tlp_ready_o = r_tlp_ready;
    end
    // Ready is registered from the next state so it stays low while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tlp_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
        end else begin
            r_tlp_ready <= w_next == IDLE;
            r_awvalid   <= w_go | (r_awvalid & ~awready_i);
            r_wvalid    <= w_go | (r_wvalid & ~wready_i);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
            r_reqid   <= '0;
        end else if (w_go) begin
            r_awid    <= ID_WIDTH'(AXI_ID);
            r_awaddr  <= tlp_addr_i & ~32'hF;
            r_awlen   <= 8'd0;
            r_awsize  <= 3'b100;
            r_awburst <= 2'b01;
            r_wdata   <= tlp_data_i << {tlp_addr_i[3:2], 5'b00000};
            r_wstrb   <= w_len_mask << {tlp_addr_i[3:2], 2'b00};
            r_wlast   <= 1'b1;
            r_reqid   <= tlp_reqid_i;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_cnt <= '0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop && ~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            if (w_b_done && w_b_ok && ~&r_done_cnt) r_done_cnt <= r_done_cnt + CNT_WIDTH'(1);
            if (w_b_done && !w_b_ok && ~&r_err_cnt) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end
    assign awvalid_o     = r_awvalid;
    assign awid_o        = r_awid;
    assign awaddr_o      = r_awaddr;
    assign awlen_o       = r_awlen;
    assign awsize_o      = r_awsize;
    assign awburst_o     = r_awburst;
    assign wvalid_o      = r_wvalid;
    assign wdata_o       = r_wdata;
    assign wstrb_o       = r_wstrb;
    assign wlast_o       = r_wlast;
    assign wr_done_cnt_o = r_done_cnt;
    assign drop_cnt_o    = r_drop_cnt;
    assign err_cnt_o     = r_err_cnt;
    assign last_reqid_o  = r_reqid;
endmodule
